// File: rtl/afifo_pkg.sv
// Shared async-FIFO constants and pointer-width helpers used by both the read and write sides.
package afifo_pkg;

  localparam int AFIFO_ADDRSIZE = 4;
  localparam int AFIFO_PTR_W    = AFIFO_ADDRSIZE + 1;

  function automatic int fifo_depth(input int asize);
    return 32'sd1 << asize;
  endfunction

  // Gray pointers carry one extra wrap bit beyond the address
  function automatic int ptr_width(input int asize);
    return asize + 32'sd1;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic [WIDTH-1:0] bin_s;

  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_s[i] = ^(gray >> i);
    end
  end

  assign bin = bin_s;

endmodule

// File: rtl/wptr_full.sv
// Async-FIFO write-side pointer, full/free tracking and sticky overflow.
// Almost-full output is built only when WPTR_FULL_AFULL_EN is defined; otherwise wafull is tied low.
module wptr_full
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE     = AFIFO_ADDRSIZE,
  parameter int AFULL_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                wpush,
  input  logic [ADDRSIZE:0]   rptr_wclk,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic                woverflow,
  output logic [ADDRSIZE:0]   wfree
);

  localparam int            PW    = ptr_width(ADDRSIZE);
  localparam logic [PW-1:0] DEPTH = PW'(fifo_depth(ADDRSIZE));

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic          wfull_r;
  logic          woverflow_r;
  logic [PW-1:0] wfree_r;

  logic          push_s;
  logic [PW-1:0] n_wbin_s;
  logic [PW-1:0] n_wptr_s;
  logic [PW-1:0] rbin_w_s;
  logic [PW-1:0] n_free_s;
  logic          n_full_s;

  gray2bin #(
    .WIDTH(PW)
  ) u_rptr_g2b (
    .gray(rptr_wclk),
    .bin (rbin_w_s)
  );

  assign push_s   = wpush & ~wfull_r;
  assign n_wbin_s = wbin_r + {{(PW-1){1'b0}}, push_s};
  assign n_wptr_s = (n_wbin_s >> 1) ^ n_wbin_s;

  // Full when the write pointer is one lap ahead: top two Gray bits differ, rest match
  assign n_full_s = (n_wptr_s == {~rptr_wclk[ADDRSIZE:ADDRSIZE-1], rptr_wclk[ADDRSIZE-2:0]});
  assign n_free_s = DEPTH - (n_wbin_s - rbin_w_s);

  // Pointer, full, free and overflow state
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_r      <= '0;
      wptr_r      <= '0;
      wfull_r     <= 1'b0;
      woverflow_r <= 1'b0;
      wfree_r     <= DEPTH;
    end else begin
      wbin_r      <= n_wbin_s;
      wptr_r      <= n_wptr_s;
      wfull_r     <= n_full_s;
      woverflow_r <= woverflow_r | (wpush & wfull_r);
      wfree_r     <= n_free_s;
    end
  end

`ifdef WPTR_FULL_AFULL_EN
  localparam logic [PW-1:0] AFULL_LIMIT = PW'(AFULL_THRESH);
  logic wafull_r;

  // Almost-full threshold register
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wafull_r <= 1'b0;
    end else begin
      wafull_r <= (n_free_s <= AFULL_LIMIT);
    end
  end

  assign wafull = wafull_r;
`else
  // Threshold has no effect in this build
  logic unused_afull_thresh_s;
  assign unused_afull_thresh_s = ^AFULL_THRESH;
  assign wafull                = 1'b0;
`endif

  assign wen       = wpush & ~wfull_r & ~wrst;
  assign waddr     = wbin_r[ADDRSIZE-1:0];
  assign wptr      = wptr_r;
  assign wfull     = wfull_r;
  assign woverflow = woverflow_r;
  assign wfree     = wfree_r;

endmodule
